// File: rtl/imem_pkg.sv
// Shared constants and state type for the instruction RAM fill sequencer.
// Checksum option is selected with IMEM_FILL_CHECKSUM_EN.
package imem_pkg;
   localparam int IMEM_DEPTH  = 64;
   localparam int IMEM_ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      RUN
   } fillState_t;

   localparam logic [31:0] ADDR_RST = 32'h0;
   localparam logic [31:0] FILL_RST = 32'h0;
endpackage

// File: rtl/imem_fill_ctrl.sv
// Loads the instruction RAM from a host stream and stalls the core until done.
// Define IMEM_FILL_CHECKSUM_EN to accumulate a sum of the loaded words.
module imem_fill_ctrl
   import imem_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Start_FL0,
   input  logic              HostValid_FL0,
   input  logic [31:0]       HostData_FL0,
   input  logic              HostLast_FL0,
   output logic              HostReady_FL0,
   output logic [31:0]       IntrAddr_FL0,
   output logic [31:0]       IntrFill_FL0,
   output logic              CoreStall_FL0,
   output logic              LoadDone_FL0,
   output logic [ADDR_W:0]   WordCount_FL0,
   output logic              LoadErr_FL0,
   output logic [31:0]       Checksum_FL0
);

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

   fillState_t state, stateN;

   logic              accept;
   logic              lastWord;
   logic              clrLoad;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       addrN;
   logic [31:0]       fillN;
   logic [ADDR_W:0]   cntN;
   logic              errN;
   logic              readyN;
   logic              stallN;
   logic              doneN;

   // Ready is only ever high in LOAD, so accept implies LOAD.
   assign accept   = HostValid_FL0 & HostReady_FL0;
   assign lastWord = (WordCount_FL0 == LAST_IDX);
   assign ptr      = WordCount_FL0[ADDR_W-1:0];
   assign clrLoad  = Start_FL0 & ((state == IDLE) | (state == RUN));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         IntrAddr_FL0  <= ADDR_RST;
         IntrFill_FL0  <= FILL_RST;
         WordCount_FL0 <= '0;
         LoadErr_FL0   <= 1'b0;
         HostReady_FL0 <= 1'b0;
         CoreStall_FL0 <= 1'b1;
         LoadDone_FL0  <= 1'b0;
      end else begin
         state         <= stateN;
         IntrAddr_FL0  <= addrN;
         IntrFill_FL0  <= fillN;
         WordCount_FL0 <= cntN;
         LoadErr_FL0   <= errN;
         HostReady_FL0 <= readyN;
         CoreStall_FL0 <= stallN;
         LoadDone_FL0  <= doneN;
      end
   end

   always_comb begin
      stateN = state;
      unique case (state)
         IDLE:  if (Start_FL0) stateN = LOAD;
         LOAD:  if (accept && (HostLast_FL0 || lastWord))
                   stateN = DRAIN;
         DRAIN: stateN = RUN;
         RUN:   if (Start_FL0) stateN = LOAD;
         default: stateN = IDLE;
      endcase
   end

   // Stall drops only after a full cycle in RUN, giving the RAM time
   // to capture the last word; it rises at once on a reload.
   always_comb begin
      addrN  = IntrAddr_FL0;
      fillN  = IntrFill_FL0;
      cntN   = WordCount_FL0;
      errN   = LoadErr_FL0;
      readyN = (stateN == LOAD);
      doneN  = (stateN == RUN);
      stallN = !((state == RUN) && (stateN == RUN));
      if (clrLoad) begin
         cntN = '0;
         errN = 1'b0;
      end else if (accept) begin
         addrN = {{(32-ADDR_W){1'b0}}, ptr};
         fillN = HostData_FL0;
         cntN  = WordCount_FL0 + ONE;
         if (lastWord && !HostLast_FL0)
            errN = 1'b1;
      end
   end

`ifdef IMEM_FILL_CHECKSUM_EN
   logic [31:0] sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sum <= '0;
      else if (clrLoad)
         sum <= '0;
      else if (accept)
         sum <= sum + HostData_FL0;
   end

   assign Checksum_FL0 = sum;
`else
   assign Checksum_FL0 = '0;
`endif

endmodule

// File: doc/imem_fill_ctrl.md
Name: imem_fill_ctrl

Overview:
- Sequencer for the 64-word instruction RAM fill port (IntrAddr_FL0/IntrFill_FL0).
- The RAM has no write enable and writes every clock, so this block always presents a safe address/data pair.
- Loads a program word-by-word from a host valid/ready stream into consecutive RAM words starting at 0.
- Stalls the core until the last word is physically written, then releases it; supports reload on a new Start.

Parameters:
DEPTH, 64, number of instruction words in the RAM
ADDR_W, 6, word-address width (log2 DEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
Start_FL0  in  1  single-cycle pulse; begin a (re)load
HostValid_FL0  in  1  host word valid
HostData_FL0  in  32  host instruction word
HostLast_FL0  in  1  marks final word of program, qualified by HostValid_FL0
HostReady_FL0  out  1  block accepts a word this cycle
IntrAddr_FL0  out  32  RAM word address; bits [ADDR_W-1:0] used, upper bits 0
IntrFill_FL0  out  32  RAM write data
CoreStall_FL0  out  1  hold core fetch/PC while high
LoadDone_FL0  out  1  high in RUN
WordCount_FL0  out  ADDR_W+1  words accepted in current/last load
LoadErr_FL0  out  1  sticky: RAM filled without HostLast_FL0
Checksum_FL0  out  32  see Optional Feature

Behaviour:
- Reset (async, active-high): state IDLE, IntrAddr_FL0=0, IntrFill_FL0=0, HostReady_FL0=0, CoreStall_FL0=1, LoadDone_FL0=0, WordCount_FL0=0, LoadErr_FL0=0, Checksum_FL0=0, pointer=0.
- While in reset and in IDLE, the RAM rewrites word 0 with 0. This is accepted.
- All outputs are registered. HostReady_FL0 is a decode of state.
- States:
  - IDLE: HostReady_FL0=0, core stalled. Start_FL0 -> LOAD. Clear pointer, WordCount, LoadErr, Checksum.
  - LOAD: HostReady_FL0=1, CoreStall_FL0=1.
    - Accept = HostValid_FL0 & HostReady_FL0.
    - On accept: IntrAddr_FL0<=pointer, IntrFill_FL0<=HostData_FL0, pointer++, WordCount++.
    - Accept with HostLast_FL0, or accept of word DEPTH-1 -> DRAIN.
    - If word DEPTH-1 is accepted without HostLast_FL0, set LoadErr_FL0.
    - No accept: IntrAddr/IntrFill hold. The same pair is rewritten, which is idempotent.
  - DRAIN: HostReady_FL0=0. Exactly 1 cycle, during which the RAM captures the last word. -> RUN.
  - RUN: CoreStall_FL0=0, LoadDone_FL0=1, HostReady_FL0=0. IntrAddr/IntrFill hold the last pair. Start_FL0 -> LOAD, with the same clears as IDLE->LOAD and CoreStall_FL0=1 from the next cycle.
- Latency: the word accepted at edge k is on the fill port after k and written at edge k+1. CoreStall_FL0 falls after edge k+2 when word k is the last word.
- Boundary and corner cases:
  - Start_FL0 in LOAD or DRAIN is ignored.
  - HostValid_FL0 in IDLE, DRAIN or RUN is not accepted, since ready is 0.
  - Start_FL0 and HostValid_FL0 in the same IDLE cycle: only the transition happens; no word is accepted.
  - A 1-word load (HostLast_FL0 on the first word) is legal; WordCount_FL0=1.
  - The pointer never wraps: at most DEPTH accepts per load. WordCount_FL0 reaches DEPTH (needs ADDR_W+1 bits).
  - HostLast_FL0 without HostValid_FL0 is ignored.
  - Reset mid-load returns to IDLE with the core stalled. Partial RAM contents are undefined for software.
  - Words beyond WordCount_FL0 keep their old contents.

Optional Feature:
- Macro IMEM_FILL_CHECKSUM_EN.
- Defined: Checksum_FL0 accumulates the mod-2^32 sum of every accepted HostData_FL0 in the current load. It is cleared on Start_FL0 and stable in DRAIN/RUN.
- Undefined: Checksum_FL0 is tied to 0 and no accumulator logic is present. All other behaviour is identical.

Decomposition:
- Shared package imem_pkg holds:
  - IMEM_DEPTH=64, IMEM_ADDR_W=6
  - fill-state enum {IDLE, LOAD, DRAIN, RUN}
  - reset constants for IntrAddr/IntrFill
- No sub-module is required. The checksum accumulator may be a small sub-module imem_fill_cksum, instantiated under the macro.

Test Plan:
- Reset, no Start, 10 cycles -> CoreStall_FL0=1, HostReady_FL0=0, IntrAddr_FL0=0, IntrFill_FL0=0, LoadDone_FL0=0.
- Start, then 3 back-to-back words 0x20080005, 0x20090007, 0x01095020 (last on 3rd) -> RAM[0..2] hold them. WordCount_FL0=3. CoreStall_FL0 falls 2 cycles after the 3rd accept. LoadErr_FL0=0.
- Same load with HostValid_FL0 gaps of 2 cycles between words -> identical RAM contents. Fill port holds the previous pair during gaps, with no corruption of other words.
- Start, 64 words 0x1000+i, no HostLast_FL0 -> HostReady_FL0 drops after the 64th accept. WordCount_FL0=64. LoadErr_FL0=1. RAM[63]=0x103F.
- In RUN, Start, then reload 1 word 0xDEADBEEF with last -> core stalled during reload. RAM[0]=0xDEADBEEF. RAM[1..] unchanged. LoadErr_FL0 cleared. With IMEM_FILL_CHECKSUM_EN, Checksum_FL0=0xDEADBEEF.
- Assert reset for 1 cycle mid-LOAD after 5 words -> immediate IDLE, CoreStall_FL0=1, WordCount_FL0=0. A subsequent Start and load completes normally.
